// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard controller: mult/div FSM states
// and the default mult/div latency.
package cpu_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: an accepted issue loads LATENCY-1 into a down-counter;
// the unit reads busy for exactly LATENCY cycles, starting the cycle after issue.
module md_busy_timer
  import cpu_pkg::*;
#(
  parameter int LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      issue_i,
  output md_state_e state_o
);

  localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

  md_state_e  state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      md_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // The counter stops at zero; leaving MD_BUSY takes one more cycle.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      IDLE: begin
        if (issue_i) begin
          state_d  = MD_BUSY;
          md_cnt_d = LOAD_VAL;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch/jump flush and mult/div busy stalls.
// Optional saturating stall/flush counters are enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             ID_MdIssue,
  input  logic             ID_ReadsHiLo,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_BranchTaken,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             IF_ID_stall,
  output logic             IF_ID_clear,
  output logic             ID_EX_clear,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  md_state_e md_state;
  logic      lu;
  logic      mdh;
  logic      md_issue_ok;

  md_busy_timer #(
    .LATENCY(MD_LATENCY)
  ) u_md_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .issue_i (md_issue_ok),
    .state_o (md_state)
  );

  // Reset aborts a busy period immediately, not just at the next edge.
  assign md_busy = reset && (md_state == MD_BUSY);

  assign lu  = EX_MemRead && (EX_Rt != 5'd0) &&
               ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  assign mdh = md_busy && (ID_MdIssue || ID_ReadsHiLo);

  always_comb begin
    PC_Wr       = 1'b1;
    IF_ID_stall = 1'b1;
    IF_ID_clear = 1'b1;
    ID_EX_clear = 1'b1;
    md_issue_ok = 1'b0;
    if (!reset) begin
      PC_Wr       = 1'b0;
      IF_ID_clear = 1'b0;
      ID_EX_clear = 1'b0;
    end else if (EX_BranchTaken) begin
      IF_ID_clear = 1'b0;
      ID_EX_clear = 1'b0;
    end else if (mdh || lu) begin
      PC_Wr       = 1'b0;
      IF_ID_stall = 1'b0;
      ID_EX_clear = 1'b0;
    end else begin
      if (ID_Jump) begin
        IF_ID_clear = 1'b0;
      end
      md_issue_ok = ID_MdIssue;
    end
  end

  assign IF_ID_Wr = PC_Wr;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_Wr && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!IF_ID_clear && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// sequences and randomized stimulus against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int CW    = 8;
  localparam int SAT_V = (1 << CW) - 1;

  // Packed expected-output order: {PC_Wr, IF_ID_Wr, IF_ID_stall, IF_ID_clear, ID_EX_clear, md_busy}
  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       md_issue;
    logic       reads_hilo;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       br;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    ID_Rs, ID_Rt, EX_Rt;
  logic          ID_UsesRt, ID_Jump, ID_MdIssue, ID_ReadsHiLo, EX_MemRead, EX_BranchTaken;
  logic          PC_Wr, IF_ID_Wr, IF_ID_stall, IF_ID_clear, ID_EX_clear, md_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(
    .MD_LATENCY(LAT),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Jump        (ID_Jump),
    .ID_MdIssue     (ID_MdIssue),
    .ID_ReadsHiLo   (ID_ReadsHiLo),
    .EX_MemRead     (EX_MemRead),
    .EX_Rt          (EX_Rt),
    .EX_BranchTaken (EX_BranchTaken),
    .PC_Wr          (PC_Wr),
    .IF_ID_Wr       (IF_ID_Wr),
    .IF_ID_stall    (IF_ID_stall),
    .IF_ID_clear    (IF_ID_clear),
    .ID_EX_clear    (ID_EX_clear),
    .md_busy        (md_busy),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         busy_left = 0;
  int         m_stall   = 0;
  int         m_flush   = 0;
  logic [5:0] exp_q[$];

  function automatic in_t mk(logic rst_n, logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                             logic jump, logic md, logic hilo, logic memread,
                             logic [4:0] ex_rt, logic br);
    in_t t;
    t.rst_n = rst_n; t.rs = rs; t.rt = rt; t.uses_rt = uses_rt; t.jump = jump;
    t.md_issue = md; t.reads_hilo = hilo; t.ex_memread = memread; t.ex_rt = ex_rt; t.br = br;
    return t;
  endfunction

  // Reference: priority rules applied to the inputs and the model's busy flag.
  function automatic logic [5:0] ref_out(in_t in, logic busy);
    logic hz_lu, hz_md;
    if (!in.rst_n) return 6'b001000;
    hz_lu = in.ex_memread && (in.ex_rt != 5'd0) &&
            ((in.ex_rt == in.rs) || (in.uses_rt && (in.ex_rt == in.rt)));
    hz_md = busy && (in.md_issue || in.reads_hilo);
    if (in.br)            return {5'b11100, busy};
    if (hz_lu || hz_md)   return {5'b00010, busy};
    if (in.jump)          return {5'b11101, busy};
    return {5'b11111, busy};
  endfunction

  function automatic logic [CW-1:0] cnt_exp(int v);
`ifdef HAZARD_PERF_CNT_EN
    return CW'(v);
`else
    return CW'(v * 0);
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(in_t in);
    reset          = in.rst_n;
    ID_Rs          = in.rs;
    ID_Rt          = in.rt;
    ID_UsesRt      = in.uses_rt;
    ID_Jump        = in.jump;
    ID_MdIssue     = in.md_issue;
    ID_ReadsHiLo   = in.reads_hilo;
    EX_MemRead     = in.ex_memread;
    EX_Rt          = in.ex_rt;
    EX_BranchTaken = in.br;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(in_t in, output logic [5:0] got);
    logic [5:0] e;
    logic       busy;
    @(negedge clk);
    drive(in);
    #1;
    busy = in.rst_n && (busy_left > 0);
    exp_q.push_back(ref_out(in, busy));
    got = {PC_Wr, IF_ID_Wr, IF_ID_stall, IF_ID_clear, ID_EX_clear, md_busy};
    e = exp_q.pop_front();
    check("outputs", 32'(got), 32'(e));
    check("stall_cnt", 32'(stall_cnt), 32'(cnt_exp(m_stall)));
    check("flush_cnt", 32'(flush_cnt), 32'(cnt_exp(m_flush)));
    if (!in.rst_n) begin
      busy_left = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      if (in.md_issue && !in.br && e[5]) busy_left = LAT;
      else if (busy_left > 0)            busy_left--;
      if (!e[5]) m_stall = (m_stall < SAT_V) ? m_stall + 1 : SAT_V;
      if (!e[2]) m_flush = (m_flush < SAT_V) ? m_flush + 1 : SAT_V;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t       tv[11];
    logic [5:0] got;
    in_t        idle_in, t;
    int         s0, f0;

    idle_in = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    tv[0]  = '{mk(1, 8, 0, 0, 0, 0, 0, 1, 8, 0),  6'b000100}; // load-use on rs
    tv[1]  = '{mk(1, 8, 0, 0, 0, 0, 0, 0, 8, 0),  6'b111110}; // load gone
    tv[2]  = '{mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0),  6'b111110}; // register zero
    tv[3]  = '{mk(1, 3, 9, 0, 0, 0, 0, 1, 9, 0),  6'b111110}; // rt match, rt unused
    tv[4]  = '{mk(1, 3, 9, 1, 0, 0, 0, 1, 9, 0),  6'b000100}; // rt match, rt used
    tv[5]  = '{mk(1, 8, 0, 0, 0, 0, 0, 1, 8, 1),  6'b111000}; // branch over load-use
    tv[6]  = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0),  6'b111010}; // jump
    tv[7]  = '{mk(1, 5, 0, 0, 1, 0, 0, 1, 5, 0),  6'b000100}; // load-use over jump
    tv[8]  = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1),  6'b111000}; // branch over jump
    tv[9]  = '{mk(0, 8, 0, 0, 1, 0, 0, 1, 8, 1),  6'b001000}; // reset forces outputs
    tv[10] = '{mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0),  6'b111110}; // mfhi while idle

    repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), got);
    check("reset_state", 32'(got), 32'(6'b001000));

    for (int i = 0; i < 11; i++) begin
      step(tv[i].in, got);
      check($sformatf("vec%0d", i), 32'(got), 32'(tv[i].exp));
    end

    // mult at cycle 0, mfhi held in ID stalls for cycles 1..LAT
    step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), got);
    check("md_issue_accept", 32'(got), 32'(6'b111110));
    for (int k = 1; k <= LAT; k++) begin
      step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0), got);
      check($sformatf("mfhi_stall_c%0d", k), 32'(got), 32'(6'b000101));
    end
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0), got);
    check("mfhi_release", 32'(got), 32'(6'b111110));

    // squashed issue does not start the unit
    step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1), got);
    check("squashed_issue", 32'(got), 32'(6'b111000));
    step(idle_in, got);
    check("squashed_no_busy", 32'(got), 32'(6'b111110));

    // second mult while busy waits, then issues once the unit is free
    step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), got);
    for (int k = 1; k <= LAT; k++) begin
      step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), got);
      check("md_reissue_stall", 32'(got), 32'(6'b000101));
    end
    step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), got);
    check("md_reissue_accept", 32'(got), 32'(6'b111110));
    repeat (LAT + 1) step(idle_in, got);
    check("md_done", 32'(got), 32'(6'b111110));

    // taken branch during load-use: stall count unchanged, flush count +1
    s0 = m_stall;
    f0 = m_flush;
    step(mk(1, 8, 0, 0, 0, 0, 0, 1, 8, 1), got);
    check("br_lu_out", 32'(got), 32'(6'b111000));
    step(idle_in, got);
    check("br_lu_stall_cnt", 32'(stall_cnt), 32'(cnt_exp(s0)));
    check("br_lu_flush_cnt", 32'(flush_cnt), 32'(cnt_exp(f0 + 1)));

    // reset during the second busy cycle aborts the busy period
    step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), got);
    step(idle_in, got);
    check("busy_c1", 32'(got[0]), 32'(1'b1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), got);
    check("busy_in_reset", 32'(got), 32'(6'b001000));
    step(idle_in, got);
    check("after_reset_out", 32'(got), 32'(6'b111110));
    check("after_reset_stall", 32'(stall_cnt), 32'(0));
    check("after_reset_flush", 32'(flush_cnt), 32'(0));

    // randomized stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      t.rst_n      = ($urandom_range(0, 99) != 0);
      t.rs         = 5'($urandom_range(0, 3));
      t.rt         = 5'($urandom_range(0, 3));
      t.uses_rt    = 1'($urandom_range(0, 1));
      t.jump       = ($urandom_range(0, 5) == 0);
      t.md_issue   = ($urandom_range(0, 7) == 0);
      t.reads_hilo = ($urandom_range(0, 3) == 0);
      t.ex_memread = ($urandom_range(0, 2) == 0);
      t.ex_rt      = 5'($urandom_range(0, 3));
      t.br         = ($urandom_range(0, 7) == 0);
      step(t, got);
    end

    // counter saturation
    repeat (LAT + 2) step(idle_in, got);
    repeat (SAT_V + 40) step(mk(1, 6, 0, 0, 0, 0, 0, 1, 6, 0), got);
    step(idle_in, got);
    check("stall_cnt_sat", 32'(stall_cnt), 32'(cnt_exp(SAT_V)));
    repeat (SAT_V + 40) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), got);
    step(idle_in, got);
    check("flush_cnt_sat", 32'(flush_cnt), 32'(cnt_exp(SAT_V)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It generates the PC write enable and the IF/ID and ID/EX control signals (write enable, active-low stall, active-low clear) that the pipeline registers consume. It detects load-use hazards, taken branches and jumps, and multiply/divide busy conditions. Inputs come from the ID and EX stages; outputs drive the PC register, `IF_ID_Reg` and the ID/EX register.

## Interface
Parameters:
- `MD_LATENCY`, default 32: cycles the mult/div unit stays busy after issue; legal range 2..255.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: the single clock; all state is updated on its rising edge.
- `reset` in 1: synchronous, active-low.
- `ID_Rs`, `ID_Rt` in 5: source register fields of the instruction in ID.
- `ID_UsesRt` in 1: the ID instruction reads `rt` as a source.
- `ID_Jump` in 1: the ID instruction is j/jal/jr/jalr.
- `ID_MdIssue` in 1: the ID instruction is mult/multu/div/divu.
- `ID_ReadsHiLo` in 1: the ID instruction is mfhi/mflo.
- `EX_MemRead` in 1: the EX instruction is a load.
- `EX_Rt` in 5: destination register of the EX load.
- `EX_BranchTaken` in 1: the branch in EX resolved taken.
- `PC_Wr` out 1: PC update enable.
- `IF_ID_Wr` out 1: IF/ID write enable.
- `IF_ID_stall` out 1: active-low; 0 holds IF/ID.
- `IF_ID_clear` out 1: active-low; 0 zeroes IF/ID.
- `ID_EX_clear` out 1: active-low; 0 inserts a bubble into ID/EX.
- `md_busy` out 1: the mult/div unit is busy.
- `stall_cnt` out `CNT_W`: stall-cycle performance counter.
- `flush_cnt` out `CNT_W`: flush performance counter.

## Operation
- FSM states:
  - `IDLE`: mult/div unit free.
  - `MD_BUSY`: down-counter `md_cnt` is running.
- Transitions:
  - `IDLE` → `MD_BUSY` when `ID_MdIssue` is accepted (no stall or flush in that cycle); `md_cnt` loads `MD_LATENCY-1`.
  - In `MD_BUSY`, `md_cnt` decrements each cycle.
  - `MD_BUSY` → `IDLE` on the cycle after `md_cnt` reaches 0.
- `md_busy` = 1 exactly when the state is `MD_BUSY`.
- Conditions, all combinational on the current inputs and state:
  - `lu` = `EX_MemRead` & `EX_Rt`≠0 & (`EX_Rt`==`ID_Rs` | (`ID_UsesRt` & `EX_Rt`==`ID_Rt`)).
  - `mdh` = `md_busy` & (`ID_MdIssue` | `ID_ReadsHiLo`).
- Output priority, highest first:
  1. `EX_BranchTaken`: `IF_ID_clear`=0 and `ID_EX_clear`=0; `PC_Wr`=1; `IF_ID_stall`=1. Any pending `lu`/`mdh` is discarded because the ID instruction is squashed.
  2. `mdh` or `lu`: `PC_Wr`=0, `IF_ID_stall`=0, `ID_EX_clear`=0; `IF_ID_clear`=1.
  3. `ID_Jump`: `IF_ID_clear`=0; `PC_Wr`=1; `ID_EX_clear`=1.
  4. Default: all enables 1, all active-low signals 1.
- `IF_ID_Wr` = `PC_Wr` in every case.
- A squashed `ID_MdIssue` (same cycle as `EX_BranchTaken`) does not start `MD_BUSY`.

## Timing
- While `reset`=0 at the rising edge: state ← `IDLE`, `md_cnt` ← 0, both counters ← 0.
- During reset, outputs are forced to: `PC_Wr`=0, `IF_ID_Wr`=0, `IF_ID_stall`=1, `IF_ID_clear`=0, `ID_EX_clear`=0, `md_busy`=0.
- If reset is asserted while in `MD_BUSY`, the busy period is aborted immediately.
- Hazard outputs are Mealy: they respond in the same cycle as the inputs, with zero latency.
- A load-use stall lasts exactly 1 cycle, because the load leaves EX on the next edge.
- `md_busy` is 1 for exactly `MD_LATENCY` cycles, beginning the cycle after the issue edge.
- An `mdh` stall releases in the cycle where `md_busy` first reads 0.
- `md_cnt` is 8 bits wide and never wraps, since decrement stops at 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on each clocked cycle with `PC_Wr`=0 outside reset.
  - `flush_cnt` increments on each clocked cycle with `IF_ID_clear`=0 outside reset.
  - Both counters saturate at all-ones.
- `HAZARD_PERF_CNT_EN` undefined: `stall_cnt` and `flush_cnt` are constant 0 and no counter flops exist.

## Structure
- Shared package `cpu_pkg`: the FSM state enum (`IDLE`, `MD_BUSY`) and the default `MD_LATENCY` constant.
- One natural sub-module, `md_busy_timer`: the load/decrement counter plus the busy flag.

## Test plan
- Load-use on `rs`: `EX_MemRead`=1, `EX_Rt`=8, `ID_Rs`=8 → for 1 cycle `PC_Wr`=0, `IF_ID_stall`=0, `ID_EX_clear`=0; next cycle with `EX_MemRead`=0 all signals are 1.
- Register zero: `EX_Rt`=0, `ID_Rs`=0, `EX_MemRead`=1 → no stall. `ID_UsesRt`=0 with a match on `rt` only → no stall.
- Taken branch during load-use: `EX_BranchTaken`=1 with `lu` active → `IF_ID_clear`=0, `ID_EX_clear`=0, `PC_Wr`=1; `stall_cnt` unchanged, `flush_cnt` +1.
- Mult then mfhi, with `MD_LATENCY`=4: issue at cycle 0 → `md_busy`=1 for cycles 1–4; an mfhi held in ID is stalled for cycles 1–4 and proceeds at cycle 5.
- Jump: `ID_Jump`=1 → `IF_ID_clear`=0, `ID_EX_clear`=1, `PC_Wr`=1.
- Reset mid-busy: `reset`=0 during cycle 2 of `MD_BUSY` → next cycle `md_busy`=0, counters 0. Repeat the scenarios with the macro undefined → counters stay 0.
